// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit/receive blocks.
package spart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [2:0] STAT_FLAGS = 3'd0;
  localparam logic [2:0] STAT_COUNT = 3'd1;
  localparam logic [2:0] STAT_DIV   = 3'd2;

  localparam logic [DIV_W-1:0] DIV_MIN = 16'd2;

  // Divisors below DIV_MIN would collapse the bit period, so they are clamped.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/spart_fifo.sv
// Byte FIFO shared by the SPART transmit and receive paths.
module spart_fifo
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: send-strobe decode, TX FIFO, 8N1 serializer and status readback.
module spart_tx
  import spart_pkg::*;
#(
  parameter int unsigned      DEPTH   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = 16'd5208
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic              send_sel,
  input  logic [BYTE_W-1:0] send_data,
  input  logic [2:0]        spart_addr,
  output logic [STAT_W-1:0] status_data,
  output logic              txd,
  output logic              tx_full,
  output logic              tx_busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_cur_q, div_cur_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              ovf_q, ovf_d;

  logic              fifo_push, fifo_pop;
  logic [BYTE_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  assign fifo_push = send && !send_sel;

  spart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (send_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serializer; the divisor is latched at frame start so mid-frame writes wait a frame.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_cur_d = div_cur_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          div_cur_d = eff_div(div_q);
          baud_d    = eff_div(div_q) - 16'd1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d    = div_cur_q - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = div_cur_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) state_d = ST_IDLE;
        else              baud_d  = baud_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (send && send_sel) div_d = {div_q[7:0], send_data};
    ovf_d = ovf_q | (fifo_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      div_cur_q <= DIV_MIN;
      div_q     <= DIV_RST;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_cur_q <= div_cur_d;
      div_q     <= div_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign txd     = txd_q;
  assign tx_full = fifo_full;
  assign tx_busy = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    status_data = '0;
    case (spart_addr)
      STAT_FLAGS: status_data = {11'h0, ovf_q, tx_full, fifo_empty, tx_busy, txd_q};
      STAT_COUNT: status_data = {11'h0, 5'(fifo_count)};
      STAT_DIV:   status_data = div_q;
      default:    status_data = '0;
    endcase
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: vector table for a full frame plus hand-written corner sequences.
module tb_spart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send;
  logic        send_sel;
  logic [7:0]  send_data;
  logic [2:0]  spart_addr;
  logic [15:0] status_data;
  logic        txd;
  logic        tx_full;
  logic        tx_busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  spart_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .send        (send),
    .send_sel    (send_sel),
    .send_data   (send_data),
    .spart_addr  (spart_addr),
    .status_data (status_data),
    .txd         (txd),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy)
  );

  typedef struct {
    logic        send;
    logic        sel;
    logic [7:0]  data;
    logic [2:0]  addr;
    int          hold;
    logic [15:0] exp_stat;
    logic        exp_txd;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_send(input logic sel, input logic [7:0] d);
    send      = 1'b1;
    send_sel  = sel;
    send_data = d;
    tick();
    send      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic sl, input logic [7:0] d,
                              input logic [2:0] a, input int h, input logic [15:0] es,
                              input logic et);
    vec_t v;
    v.send = s; v.sel = sl; v.data = d; v.addr = a; v.hold = h;
    v.exp_stat = es; v.exp_txd = et;
    return v;
  endfunction

  initial begin
    logic [7:0] rx;
    int         frames;
    int         extra;
    int         limit;

    send = 1'b0; send_sel = 1'b0; send_data = '0; spart_addr = '0; rst_n = 1'b0;

    // Divisor load, then one 0xA5 frame at 4 clk/bit sampled around bit edges.
    vecs.push_back(mk(1, 1, 8'h00, 3'd2, 0, 16'h5800, 1));
    vecs.push_back(mk(1, 1, 8'h04, 3'd2, 0, 16'h0004, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 0, 16'h0005, 1));
    vecs.push_back(mk(1, 0, 8'hA5, 3'd1, 0, 16'h0001, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 0, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 2, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 0, 16'h0007, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 3, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 3, 16'h0007, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 3, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 3, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 3, 16'h0007, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 3, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 2, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 0, 16'h0007, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 3, 16'h0007, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 2, 16'h0007, 1));
    vecs.push_back(mk(0, 0, 8'h00, 3'd0, 0, 16'h0005, 1));

    do_reset();

    spart_addr = 3'd0; #1;
    chk("rst_flags", status_data, 16'h0005);
    spart_addr = 3'd1; #1;
    chk("rst_count", status_data, 16'h0000);
    spart_addr = 3'd2; #1;
    chk("rst_div", status_data, 16'd5208);
    chk("rst_txd", 16'(txd), 16'h1);
    chk("rst_full", 16'(tx_full), 16'h0);
    chk("rst_busy", 16'(tx_busy), 16'h0);

    foreach (vecs[i]) begin
      send = vecs[i].send; send_sel = vecs[i].sel;
      send_data = vecs[i].data; spart_addr = vecs[i].addr;
      tick();
      send = 1'b0;
      repeat (vecs[i].hold) tick();
      chk($sformatf("vec%0d_status", i), status_data, vecs[i].exp_stat);
      chk($sformatf("vec%0d_txd", i), 16'(txd), 16'(vecs[i].exp_txd));
    end

    // Overflow: 10 back-to-back bytes at div=4; the 10th must be dropped.
    do_send(1'b0, 8'hFF);
    for (int k = 1; k <= 9; k++) do_send(1'b0, 8'h30 + 8'(k));
    spart_addr = 3'd0; #1;
    chk("ovf_flags", 16'(status_data[4:1]), 16'hD);
    chk("ovf_full", 16'(tx_full), 16'h1);
    spart_addr = 3'd1; #1;
    chk("ovf_count", status_data, 16'h0008);

    frames = 0;
    limit  = cyc + 800;
    while (frames < 8 && cyc < limit) begin
      tick();
      if (txd == 1'b0) begin
        tick(); tick();
        for (int b = 0; b < 8; b++) begin
          repeat (4) tick();
          rx[b] = txd;
        end
        repeat (4) tick();
        chk($sformatf("ovf_stop%0d", frames), 16'(txd), 16'h1);
        chk($sformatf("ovf_byte%0d", frames), 16'(rx), 16'(8'h31 + 8'(frames)));
        frames++;
      end
    end
    chk("ovf_frames", 16'(frames), 16'd8);
    extra = 0;
    repeat (60) begin
      tick();
      if (txd == 1'b0) extra++;
    end
    chk("ovf_no_10th", 16'(extra), 16'd0);
    chk("ovf_idle_busy", 16'(tx_busy), 16'h0);
    spart_addr = 3'd0; #1;
    chk("ovf_sticky", 16'(status_data[4]), 16'h1);

    // Push on the IDLE pop cycle while full is accepted without overflow.
    do_reset();
    do_send(1'b1, 8'h00);
    do_send(1'b1, 8'h04);
    do_send(1'b0, 8'hC3);
    for (int k = 0; k < 8; k++) do_send(1'b0, 8'h40 + 8'(k));
    spart_addr = 3'd1; #1;
    chk("pf_count_full", status_data, 16'h0008);
    chk("pf_full", 16'(tx_full), 16'h1);
    repeat (33) tick();
    chk("pf_idle_txd", 16'(txd), 16'h1);
    do_send(1'b0, 8'h55);
    chk("pf_count_after", status_data, 16'h0008);
    chk("pf_full_after", 16'(tx_full), 16'h1);
    spart_addr = 3'd0; #1;
    chk("pf_no_ovf", 16'(status_data[4]), 16'h0);
    chk("pf_start", 16'(txd), 16'h0);

    // Asynchronous reset in the middle of a frame.
    rst_n = 1'b0;
    #1;
    chk("arst_txd", 16'(txd), 16'h1);
    chk("arst_flags", status_data, 16'h0005);
    tick(); tick();
    rst_n = 1'b1;
    spart_addr = 3'd2; #1;
    chk("arst_div", status_data, 16'd5208);

    // Divisor clamp (1 -> 2) and a mid-frame divisor change.
    do_send(1'b1, 8'h00);
    do_send(1'b1, 8'h01);
    chk("clamp_div_raw", status_data, 16'h0001);
    do_send(1'b0, 8'h55);
    chk("cl_e1", 16'(txd), 16'h1);
    do_send(1'b0, 8'h0F);
    chk("cl_e2_start", 16'(txd), 16'h0);
    tick();
    chk("cl_e3_start", 16'(txd), 16'h0);
    tick();
    chk("cl_e4_b0", 16'(txd), 16'h1);
    do_send(1'b1, 8'h00);
    chk("cl_e5_b0", 16'(txd), 16'h1);
    do_send(1'b1, 8'h06);
    chk("cl_e6_b1", 16'(txd), 16'h0);
    chk("cl_div6", status_data, 16'h0006);
    tick(); tick();
    chk("cl_e8_b2", 16'(txd), 16'h1);
    repeat (11) tick();
    chk("cl_e19_b7", 16'(txd), 16'h0);
    tick();
    chk("cl_e20_stop", 16'(txd), 16'h1);
    tick(); tick();
    chk("cl_e22_idle", 16'(txd), 16'h1);
    tick();
    chk("cl_e23_start2", 16'(txd), 16'h0);
    repeat (5) tick();
    chk("cl_e28_start2", 16'(txd), 16'h0);
    tick();
    chk("cl_e29_b0", 16'(txd), 16'h1);
    repeat (23) tick();
    chk("cl_e52_b3", 16'(txd), 16'h1);
    tick();
    chk("cl_e53_b4", 16'(txd), 16'h0);

    // Status decode for unused addresses and count with one byte in flight.
    do_reset();
    spart_addr = 3'd5; #1;
    chk("stat_addr5", status_data, 16'h0000);
    do_send(1'b0, 8'h11);
    do_send(1'b0, 8'h22);
    do_send(1'b0, 8'h33);
    spart_addr = 3'd1; #1;
    chk("stat_count3", status_data, 16'h0002);
    spart_addr = 3'd3; #1;
    chk("stat_addr3", status_data, 16'h0000);
    spart_addr = 3'd7; #1;
    chk("stat_addr7", status_data, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
